// File: rtl/logic_gate_unit.sv
// logic_gate_unit: bitwise two-operand gate with a 2-entry result FIFO,
// valid/ready handshakes on both sides and a saturating delivery counter.
// Every output is driven straight from a register. The head-of-buffer value
// is kept in its own register so y keeps its last value once the buffer drains.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] done_cnt
);

  // Result storage and bookkeeping registers
  logic [WIDTH-1:0] mem_r [0:1];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] y_r;
  logic [CNT_W-1:0] done_cnt_r;

  // Next-state signals
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] result_s;
  logic             wr_ptr_nxt_s;
  logic             rd_ptr_nxt_s;
  logic [1:0]       count_nxt_s;
  logic [WIDTH-1:0] head_nxt_s;
  logic [CNT_W-1:0] done_cnt_nxt_s;

  // Bitwise gate selected by op; b is unused for NOT and BUF
  function automatic logic [WIDTH-1:0] gate_eval(
    input logic [2:0]       op_i,
    input logic [WIDTH-1:0] a_i,
    input logic [WIDTH-1:0] b_i
  );
    logic [WIDTH-1:0] r;
    case (op_i)
      3'b000:  r = ~a_i;
      3'b001:  r = a_i & b_i;
      3'b010:  r = a_i | b_i;
      3'b011:  r = a_i ^ b_i;
      3'b100:  r = ~(a_i & b_i);
      3'b101:  r = ~(a_i | b_i);
      3'b110:  r = ~(a_i ^ b_i);
      3'b111:  r = a_i;
      default: r = a_i;
    endcase
    return r;
  endfunction

  // Handshake decode: readiness comes from registered occupancy only
  always_comb begin
    push_s   = in_valid && (count_r != 2'd2);
    pop_s    = out_ready && (count_r != 2'd0);
    result_s = gate_eval(op, a, b);
  end

  // Pointer and occupancy next-state; simultaneous push and pop keeps occupancy
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r ^ push_s;
    rd_ptr_nxt_s = rd_ptr_r ^ pop_s;
    count_nxt_s  = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Next head value: new result if it lands in the slot that becomes the head,
  // otherwise the stored slot; an empty buffer keeps the last shown value
  always_comb begin
    head_nxt_s = y_r;
    if (count_nxt_s == 2'd0) begin
      head_nxt_s = y_r;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = result_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Delivery counter increments per output transfer and sticks at all-ones
  always_comb begin
    done_cnt_nxt_s = done_cnt_r;
    if (pop_s && (done_cnt_r != {CNT_W{1'b1}})) begin
      done_cnt_nxt_s = done_cnt_r + CNT_W'(1);
    end else begin
      done_cnt_nxt_s = done_cnt_r;
    end
  end

  // Result slot write on input transfer; stored results are never modified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= result_s;
    end else begin
      mem_r[0] <= mem_r[0];
      mem_r[1] <= mem_r[1];
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
      done_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);
      y_r         <= head_nxt_s;
      done_cnt_r  <= done_cnt_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: a default instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_logic_gate_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = 8'h00;
  logic [W-1:0] b = 8'h00;

  logic         in_ready, out_valid;
  logic [W-1:0] y;
  logic [15:0]  done_cnt;
  logic         in_ready2, out_valid2;
  logic [W-1:0] y2;
  logic [1:0]   done_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int model_cnt  = 0;
  int model_cnt2 = 0;

  logic_gate_unit #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .done_cnt(done_cnt)
  );

  logic_gate_unit #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .done_cnt(done_cnt2)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gate(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'd0: return ~x;
      3'd1: return x & z;
      3'd2: return x | z;
      3'd3: return x ^ z;
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  // Drive one cycle at the falling edge, check outputs, update the model,
  // then advance to the next falling edge.
  task automatic step(input logic iv, input logic [2:0] o, input logic [W-1:0] aa,
                      input logic [W-1:0] bb, input logic ordy);
    logic will_push, will_pop;
    in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy;
    #1;
    check_val("in_ready", in_ready, exp_q.size() != 2);
    check_val("out_valid", out_valid, exp_q.size() != 0);
    check_val("done_cnt", done_cnt, model_cnt);
    check_val("done_cnt_sat", done_cnt2, model_cnt2);
    if (exp_q.size() != 0) begin
      check_val("y", y, exp_q[0]);
      check_val("y_sat_inst", y2, exp_q[0]);
    end
    will_push = iv && (exp_q.size() != 2);
    will_pop  = ordy && (exp_q.size() != 0);
    if (will_pop) begin
      void'(exp_q.pop_front());
      model_cnt++;
      if (model_cnt2 < 3) model_cnt2++;
    end
    if (will_push) exp_q.push_back(ref_gate(o, aa, bb));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    check_val({tag, "_out_valid"}, out_valid, 1'b0);
    check_val({tag, "_in_ready"}, in_ready, 1'b1);
    check_val({tag, "_y"}, y, 8'h00);
    check_val({tag, "_done_cnt"}, done_cnt, 16'd0);
    check_val({tag, "_done_cnt_sat"}, done_cnt2, 2'd0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_cnt  = 0;
    model_cnt2 = 0;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    #1 reset_check("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Some traffic so the reset check below sees a real change
    step(1'b1, 3'd1, 8'hA5, 8'hFF, 1'b1);
    step(1'b1, 3'd2, 8'h11, 8'h22, 1'b0);
    step(1'b1, 3'd3, 8'h33, 8'h0F, 1'b0);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 reset_check("async_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // All ops back-to-back, first transfer right after reset release
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'hA5, 8'h0F, 1'b1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    check_val("all_ops_done", done_cnt, 16'd8);
    check_val("all_ops_sat", done_cnt2, 2'd3);

    // Backpressure, then full plus drain on the same edge
    step(1'b1, 3'd3, 8'h01, 8'hFF, 1'b0);
    step(1'b1, 3'd3, 8'h02, 8'hFF, 1'b0);
    step(1'b1, 3'd3, 8'h03, 8'hFF, 1'b0);
    #1 check_val("bp_hold_y", y, 8'hFE);
    check_val("bp_full", in_ready, 1'b0);
    step(1'b1, 3'd3, 8'h03, 8'hFF, 1'b1);
    #1 check_val("drain_ready", in_ready, 1'b1);
    check_val("drain_y", y, 8'hFD);
    step(1'b1, 3'd3, 8'h03, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

    // Reset mid-flight with two results buffered
    step(1'b1, 3'd1, 8'hF0, 8'h3C, 1'b0);
    step(1'b1, 3'd2, 8'hF0, 8'h3C, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_check("mid_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd0, 8'h00, 8'h00, 1'b1);
    #1 check_val("rst_then_not_y", y, 8'hFF);
    check_val("rst_then_not_valid", out_valid, 1'b1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

    // Saturation on the narrow counter: five deliveries since reset
    for (int i = 0; i < 4; i++) step(1'b1, 3'd7, 8'(i), 8'h00, 1'b1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    check_val("sat_final", done_cnt2, 2'd3);
    check_val("sat_wide", done_cnt, 16'd5);

    // Random traffic
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
           8'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the completed-result counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream offers op/a/b this cycle.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts an input this cycle.
REQ-007 The block SHALL have port op, input, 3, operation select, sampled on input transfer.
REQ-008 The block SHALL have port a, input, WIDTH, first operand.
REQ-009 The block SHALL have port b, input, WIDTH, second operand; ignored by NOT and BUF.
REQ-010 The block SHALL have port out_valid, output, 1, meaning y holds a valid result.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream accepts y this cycle.
REQ-012 The block SHALL have port y, output, WIDTH, result at the head of the output buffer.
REQ-013 The block SHALL have port done_cnt, output, CNT_W, number of results delivered since reset.

Function
REQ-014 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-015 op encoding SHALL be bitwise: 000 NOT a, 001 a AND b, 010 a OR b, 011 a XOR b, 100 NAND, 101 NOR, 110 XNOR, 111 BUF a.
REQ-016 The result SHALL be computed from op/a/b at the input-transfer edge and written into a 2-entry FIFO output buffer; no result is ever altered after capture.
REQ-017 Latency SHALL be 1 cycle: a result accepted at edge N is visible with out_valid=1 after edge N when the buffer was empty.
REQ-018 The buffer SHALL hold occupancy 0, 1 or 2; in_ready = (occupancy != 2), derived from registered occupancy only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (occupancy != 0); y SHALL show the oldest stored result and hold stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous input and output transfer SHALL leave occupancy unchanged, preserving result order.
REQ-021 With occupancy 2, in_valid SHALL be ignored (no transfer) even if out_ready=1 that cycle; the slot frees on the following cycle.
REQ-022 Input transfer with occupancy 0 and out_ready=1 SHALL NOT bypass: the result appears on the following cycle.
REQ-023 done_cnt SHALL increment by 1 on each output transfer and saturate at 2^CNT_W-1.
REQ-024 FIFO read/write pointers SHALL wrap modulo 2 without loss or duplication.
REQ-025 out_valid=0 SHALL make y a don't-care; it SHALL hold its last value, not X.

Reset
REQ-026 rst_n=0 SHALL immediately, without clock, force occupancy 0, pointers 0, out_valid=0, in_ready=1, y=0, done_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results; no transfer is recognised on any edge while rst_n=0.
REQ-028 After rst_n deasserts, the first input transfer SHALL be possible on the first rising edge.

Verification (WIDTH=8)
REQ-029 Reset: rst_n=0 asynchronously between edges -> out_valid=0, in_ready=1, y=00, done_cnt=0 without a clock edge.
REQ-030 All ops: a=A5, b=0F, out_ready=1, op 000..111 back-to-back -> y = 5A,05,AF,AA,FA,50,55,A5 in order, one per cycle after 1-cycle latency, done_cnt=8.
REQ-031 Backpressure: out_ready=0, three inputs offered (op=011, a=01/02/03, b=FF) -> first two accepted, in_ready=0 after second, y=FE held; release out_ready -> FE, FD, FC delivered in order.
REQ-032 Full plus drain: occupancy 2, in_valid=1 and out_ready=1 same edge -> one output, no input, occupancy 1, in_ready=1 next cycle.
REQ-033 Reset mid-flight: two results buffered, pulse rst_n low -> out_valid=0, done_cnt=0; next input op=000, a=00 -> y=FF after one cycle.
REQ-034 Saturation: CNT_W=2, deliver five results -> done_cnt sequence 1,2,3,3,3.
